// File: rtl/rd_burst_ctrl.sv
// Credit-based read-burst scheduler: splits a read job into memory commands of up to
// BURST_LEN words, issuing each only when the downstream sFIFO has room for the whole burst.
module rd_burst_ctrl #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 20,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 32,
    parameter int BL_W       = 6,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              cmd_vld,
    input  logic              cmd_rdy,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [BL_W-1:0]   cmd_len,
    input  logic              fifo_pop,
    output logic              busy,
    output logic              done,
    output logic              err_credit
);

    // state  | meaning
    // IDLE   | waiting for a job, req_rdy high
    // ISSUE  | sizing next burst, waiting for enough sFIFO credit
    // CMD    | command presented, waiting for cmd_rdy
    // DRAIN  | all commands issued, waiting for outstanding words to be popped
    // DONE   | job complete; done pulses on the following cycle
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W:0]   DEPTH_C     = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [BL_W-1:0]  BURST_C     = BL_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] BURST_LEN_C = LEN_W'(BURST_LEN);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  outstanding;

    logic              cmd_hs;
    logic [CNT_W:0]    out_sum;
    logic [CNT_W:0]    out_next;
    logic              pop_under;
    logic              credit_over;
    logic [BL_W-1:0]   blen;
    logic [CNT_W:0]    free_cnt;
    logic              credit_ok;

    assign req_rdy = (state == S_IDLE);
    assign busy    = (state != S_IDLE);
    assign cmd_hs  = cmd_vld & cmd_rdy;

    always_comb begin
        out_sum = {1'b0, outstanding};
        if (cmd_hs) begin
            out_sum = {1'b0, outstanding} + (CNT_W+1)'(cmd_len);
        end
        pop_under = fifo_pop && (out_sum == '0);
        out_next  = out_sum;
        if (fifo_pop && !pop_under) begin
            out_next = out_sum - 1'b1;
        end
        credit_over = (out_next > DEPTH_C);
    end

    always_comb begin
        blen = BURST_C;
        if (remaining < BURST_LEN_C) begin
            blen = remaining[BL_W-1:0];
        end
        free_cnt  = DEPTH_C - {1'b0, outstanding};
        credit_ok = (free_cnt >= (CNT_W+1)'(blen));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            err_credit  <= 1'b0;
        end else begin
            outstanding <= out_next[CNT_W-1:0];
            if (pop_under || credit_over) begin
                err_credit <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            cmd_vld   <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            done      <= 1'b0;
        end else begin
            // done is registered off the DONE state, so it lands one cycle after it
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (req_vld) begin
                        if (req_len == '0) begin
                            state <= S_DONE;
                        end else begin
                            addr_q    <= req_addr;
                            remaining <= req_len;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (credit_ok) begin
                        cmd_addr <= addr_q;
                        cmd_len  <= blen;
                        cmd_vld  <= 1'b1;
                        state    <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (cmd_rdy) begin
                        cmd_vld   <= 1'b0;
                        addr_q    <= addr_q + ADDR_W'(cmd_len);
                        remaining <= remaining - LEN_W'(cmd_len);
                        if (remaining == LEN_W'(cmd_len)) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DRAIN: begin
                    // leave as the counter reaches zero, so done trails the last pop by one cycle
                    if (out_next == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (out_next <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Directed bench for rd_burst_ctrl: burst splitting, credit stall, handshake stall,
// outstanding accounting, zero-length jobs, error flag and mid-job reset.
module tb_rd_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [23:0] req_addr;
    logic [19:0] req_len;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [23:0] cmd_addr;
    logic [5:0]  cmd_len;
    logic        fifo_pop;
    logic        busy;
    logic        done;
    logic        err_credit;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [23:0] rec_a [0:31];
    logic [5:0]  rec_l [0:31];
    int ncmd, done_cnt, done_cyc, last_pop, first_vld, npop;

    rd_burst_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .fifo_pop   (fifo_pop),
        .busy       (busy),
        .done       (done),
        .err_credit (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Runs one job with cmd_rdy high and pops whenever the bench's own occupancy is non-zero.
    task automatic run_job(input logic [23:0] a, input logic [19:0] l, input int max_cyc);
        int model_out;
        ncmd = 0; done_cnt = 0; done_cyc = -1; last_pop = -1; first_vld = -1; npop = 0;
        model_out = 0;
        cyc = 0;
        req_addr = a; req_len = l; req_vld = 1'b1; cmd_rdy = 1'b1; fifo_pop = 1'b0;
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            fifo_pop = (model_out > 0);
            if (cmd_vld && cmd_rdy) begin
                if (ncmd < 32) begin
                    rec_a[ncmd] = cmd_addr;
                    rec_l[ncmd] = cmd_len;
                end
                ncmd++;
                model_out += int'(cmd_len);
            end
            if (fifo_pop) begin
                model_out--;
                npop++;
            end
            tick();
            if (fifo_pop) last_pop = cyc;
            if (cmd_vld === 1'b1 && first_vld < 0) first_vld = cyc;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        fifo_pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_len = '0; cmd_rdy = 1'b0; fifo_pop = 1'b0;
        tick();
        tick();
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
        n_cmp++; if (cmd_vld !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_vld: got %b want 0", cmd_vld); end
        n_cmp++; if (cmd_addr !== 24'h0 || cmd_len !== 6'd0) begin n_bad++; $display("FAIL reset_cmd: got %h/%0d want 0/0", cmd_addr, cmd_len); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err_credit !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 0", busy, done, err_credit); end
        n_cmp++; if (dut.outstanding !== 10'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d want 0", dut.outstanding); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [23:0] exp_a [0:2];
        exp_a[0] = 24'h000100; exp_a[1] = 24'h000120; exp_a[2] = 24'h000140;
        run_job(24'h000100, 20'd96, 400);
        n_cmp++; if (ncmd !== 3) begin n_bad++; $display("FAIL basic_ncmd: got %0d want 3", ncmd); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rec_a[i] !== exp_a[i] || rec_l[i] !== 6'd32) begin
                n_bad++; $display("FAIL basic_cmd%0d: got %h/%0d want %h/32", i, rec_a[i], rec_l[i], exp_a[i]);
            end
        end
        n_cmp++; if (first_vld !== 2) begin n_bad++; $display("FAIL basic_first_vld_cycle: got %0d want 2", first_vld); end
        n_cmp++; if (npop !== 96) begin n_bad++; $display("FAIL basic_pops: got %0d want 96", npop); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc !== last_pop + 1) begin n_bad++; $display("FAIL basic_done_latency: got cycle %0d want %0d", done_cyc, last_pop + 1); end
        n_cmp++; if (err_credit !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err_credit); end
        n_cmp++; if (busy !== 1'b0 || req_rdy !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got busy=%b rdy=%b want 0/1", busy, req_rdy); end
    endtask

    task automatic test_short_final();
        run_job(24'h000200, 20'd70, 400);
        n_cmp++; if (ncmd !== 3) begin n_bad++; $display("FAIL short_ncmd: got %0d want 3", ncmd); end
        n_cmp++; if (rec_l[0] !== 6'd32 || rec_l[1] !== 6'd32 || rec_l[2] !== 6'd6) begin
            n_bad++; $display("FAIL short_lens: got %0d,%0d,%0d want 32,32,6", rec_l[0], rec_l[1], rec_l[2]);
        end
        n_cmp++; if (rec_a[2] !== 24'h000240) begin n_bad++; $display("FAIL short_last_addr: got %h want 000240", rec_a[2]); end
        n_cmp++; if (done_cnt !== 1 || npop !== 70) begin n_bad++; $display("FAIL short_done: got done=%0d pops=%0d want 1/70", done_cnt, npop); end
    endtask

    task automatic test_addr_wrap();
        run_job(24'hFFFFF0, 20'd40, 300);
        n_cmp++; if (ncmd !== 2) begin n_bad++; $display("FAIL wrap_ncmd: got %0d want 2", ncmd); end
        n_cmp++; if (rec_a[0] !== 24'hFFFFF0 || rec_l[0] !== 6'd32) begin n_bad++; $display("FAIL wrap_cmd0: got %h/%0d want fffff0/32", rec_a[0], rec_l[0]); end
        n_cmp++; if (rec_a[1] !== 24'h000010 || rec_l[1] !== 6'd8) begin n_bad++; $display("FAIL wrap_cmd1: got %h/%0d want 000010/8", rec_a[1], rec_l[1]); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        run_job(24'h000500, 20'd0, 20);
        n_cmp++; if (done_cnt !== 1 || done_cyc !== 2) begin n_bad++; $display("FAIL zero_done: got count=%0d cycle=%0d want 1/2", done_cnt, done_cyc); end
        n_cmp++; if (ncmd !== 0 || first_vld !== -1) begin n_bad++; $display("FAIL zero_no_cmd: got ncmd=%0d first_vld=%0d want 0/-1", ncmd, first_vld); end
    endtask

    task automatic test_cmd_stall();
        cmd_rdy = 1'b0; req_addr = 24'h000300; req_len = 20'd40; req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (cmd_vld !== 1'b1 || cmd_addr !== 24'h000300 || cmd_len !== 6'd32 || dut.outstanding !== 10'd0) begin
                n_bad++; $display("FAIL stall_hold%0d: got vld=%b %h/%0d out=%0d want 1 000300/32 out=0", i, cmd_vld, cmd_addr, cmd_len, dut.outstanding);
            end
            tick();
        end
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        n_cmp++; if (dut.outstanding !== 10'd32 || cmd_vld !== 1'b0) begin
            n_bad++; $display("FAIL stall_release: got out=%0d vld=%b want 32/0", dut.outstanding, cmd_vld);
        end
        do_reset();
    endtask

    task automatic test_simultaneous();
        cmd_rdy = 1'b1; req_addr = 24'h000400; req_len = 20'd64; req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        tick();
        tick();
        cmd_rdy = 1'b0;
        fifo_pop = 1'b1;
        for (int i = 0; i < 22; i++) tick();
        fifo_pop = 1'b0;
        n_cmp++; if (dut.outstanding !== 10'd10 || cmd_vld !== 1'b1 || cmd_addr !== 24'h000420 || cmd_len !== 6'd32) begin
            n_bad++; $display("FAIL simul_setup: got out=%0d vld=%b %h/%0d want 10 1 000420/32", dut.outstanding, cmd_vld, cmd_addr, cmd_len);
        end
        cmd_rdy = 1'b1; fifo_pop = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        n_cmp++; if (dut.outstanding !== 10'd41) begin n_bad++; $display("FAIL simul_outstanding: got %0d want 41", dut.outstanding); end
        for (int i = 0; i < 41; i++) tick();
        fifo_pop = 1'b0;
        n_cmp++; if (done !== 1'b0 || dut.outstanding !== 10'd0) begin n_bad++; $display("FAIL simul_drain: got done=%b out=%0d want 0/0", done, dut.outstanding); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL simul_done: got %b want 1", done); end
        tick();
        n_cmp++; if (done !== 1'b0 || err_credit !== 1'b0) begin n_bad++; $display("FAIL simul_done_pulse: got done=%b err=%b want 0/0", done, err_credit); end
    endtask

    task automatic test_credit_stall();
        int hs_cnt;
        int done_seen;
        hs_cnt = 0;
        cmd_rdy = 1'b1; req_addr = 24'h001000; req_len = 20'd1024; req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (cmd_vld && cmd_rdy) hs_cnt++;
            tick();
        end
        n_cmp++; if (hs_cnt !== 16) begin n_bad++; $display("FAIL credit_cmds: got %0d want 16", hs_cnt); end
        n_cmp++; if (dut.outstanding !== 10'd512 || cmd_vld !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL credit_stalled: got out=%0d vld=%b busy=%b want 512/0/1", dut.outstanding, cmd_vld, busy);
        end
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (cmd_vld && cmd_rdy) hs_cnt++;
            tick();
        end
        n_cmp++; if (hs_cnt !== 16 || cmd_vld !== 1'b0 || dut.outstanding !== 10'd511) begin
            n_bad++; $display("FAIL credit_one_pop: got cmds=%0d vld=%b out=%0d want 16/0/511", hs_cnt, cmd_vld, dut.outstanding);
        end
        fifo_pop = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        fifo_pop = 1'b0;
        n_cmp++; if (cmd_vld !== 1'b0 || dut.outstanding !== 10'd480) begin n_bad++; $display("FAIL credit_pre_release: got vld=%b out=%0d want 0/480", cmd_vld, dut.outstanding); end
        tick();
        n_cmp++; if (cmd_vld !== 1'b1 || cmd_addr !== 24'h001200 || cmd_len !== 6'd32) begin
            n_bad++; $display("FAIL credit_release: got vld=%b %h/%0d want 1 001200/32", cmd_vld, cmd_addr, cmd_len);
        end
        cmd_rdy = 1'b0;
        done_seen = 0;
        rst = 1'b1;
        tick();
        if (done === 1'b1) done_seen++;
        rst = 1'b0;
        n_cmp++; if (req_rdy !== 1'b1 || busy !== 1'b0 || cmd_vld !== 1'b0 || dut.outstanding !== 10'd0) begin
            n_bad++; $display("FAIL midreset_idle: got rdy=%b busy=%b vld=%b out=%0d want 1/0/0/0", req_rdy, busy, cmd_vld, dut.outstanding);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_seen); end
    endtask

    task automatic test_err_credit();
        n_cmp++; if (err_credit !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b want 0", err_credit); end
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        n_cmp++; if (err_credit !== 1'b1 || dut.outstanding !== 10'd0) begin
            n_bad++; $display("FAIL err_set: got err=%b out=%0d want 1/0", err_credit, dut.outstanding);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (err_credit !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_credit); end
        do_reset();
        n_cmp++; if (err_credit !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err_credit); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_final();
        test_addr_wrap();
        test_zero_len();
        test_cmd_stall();
        test_simultaneous();
        test_credit_stall();
        test_err_credit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
